clk_div_ctrl: RTL
=================

// Module: clk_div_ctrl
// PURPOSE
//  Programmable clock-divider controller: derives clk_out = clk_in / N, N >= 2.
//  Sequences divisor changes through a valid/ready config port; a new N takes effect only at a period boundary.
//  Provides a one-cycle clk_en strobe for logic that stays in the clk_in domain.
//  With DEFAULT_DIV=2, clk_out is the plain divide-by-2 clock (low out of reset).
// PARAMETERS
//  DIV_W        8   width of divisor and period counter
//  DEFAULT_DIV  2   divisor loaded at reset; must be >= 2 and < 2**DIV_W
//  CNT_W        16  width of edge counter (optional feature only)
// PORTS
//  clk_in      in   1      source clock; all logic on posedge clk_in
//  rst         in   1      reset, asynchronous, active-high
//  en          in   1      run request; 1 = produce clk_out, 0 = park low
//  cfg_valid   in   1      new divisor offered
//  cfg_div     in   DIV_W  offered divisor
//  cfg_ready   out  1      config port can accept
//  clk_out     out  1      divided clock (registered)
//  clk_en      out  1      1-cycle strobe, high in clk_out's first high cycle
//  cur_div     out  DIV_W  divisor currently in force
//  busy        out  1      state != IDLE
//  cfg_err     out  1      1-cycle pulse: rejected cfg_div (< 2)
//  edge_cnt    out  CNT_W  clk_out rising-edge count (CLK_DIV_CTRL_EDGE_CNT_EN only)
// BEHAVIOUR
//  Reset: state=IDLE, cnt=0, clk_out=0, clk_en=0, cur_div=DEFAULT_DIV, pend_div=DEFAULT_DIV, cfg_err=0.
//  Reset is asynchronous and aborts any period or pending change immediately.
//  Period counter (RUN/PEND): cnt_nxt = (cnt==cur_div-1) ? 0 : cnt+1.
//   - clk_out <= (cnt_nxt >= cur_div>>1).
//   - High for ceil(N/2) cycles, low for floor(N/2) cycles.
//   - clk_en <= (cnt_nxt == cur_div>>1).
//   - Wrap = cycle where cnt==cur_div-1.
//  FSM:
//   IDLE: cnt=0, clk_out=0. On en=1, go to RUN; the first clk_out rise is 1 edge later for N=2.
//   RUN:  count. An accepted valid cfg goes to PEND. On en=0, stop at the next wrap and go to IDLE (clk_out ends low).
//   PEND: count with the old N. At wrap, load cur_div<=pend_div, cnt<=0, go to RUN (or IDLE if en=0).
//  Config handshake:
//   - cfg_ready = (state != PEND); combinational from state.
//   - A transfer occurs when cfg_valid & cfg_ready.
//   - In IDLE, cur_div updates on the next edge.
//   - A cfg accepted in the wrap cycle goes to PEND; it applies at the following wrap, not the current one.
//  Invalid cfg_div (0 or 1):
//   - The handshake still completes.
//   - cfg_err pulses for 1 cycle.
//   - No state or divisor change.
//  Latency: en 0->1 in IDLE to the first clk_out=1 is 2 clk_in edges for any N >= 2.
//  The output never glitches: no partial period exists at any divisor switch.
// CONFIGURATION
//  CLK_DIV_CTRL_EDGE_CNT_EN defined:
//   - edge_cnt increments on every clk_en; wraps at 2**CNT_W-1 -> 0.
//   - Reset to 0; holds its value in IDLE.
//  Undefined: edge_cnt port absent; no counter logic.
// TESTING
//  1. Reset: assert rst mid-RUN -> clk_out=0, clk_en=0, busy=0, cur_div=2, cfg_ready=1 within the same cycle.
//  2. en=1, N=2 -> clk_out toggles every clk_in edge (0,1,0,1...); clk_en high on every 1.
//  3. N=5 from IDLE -> clk_out pattern 0,0,1,1,1 repeating; clk_en once per 5 cycles.
//  4. In RUN with N=4, cfg_div=6 at cnt=1 -> cfg_ready=0 until wrap; the next period is 6 cycles with no short pulse.
//  5. cfg_div=1 -> handshake completes, cfg_err pulses 1 cycle, cur_div unchanged, clk_out undisturbed.
//  6. en=0 at cnt=1, N=4 -> finishes the period, enters IDLE with clk_out=0; with the macro set, edge_cnt is frozen.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// rtl/clk_div_ctrl.sv - programmable clk_in/N divider with period-boundary divisor changes
// Optional rising-edge counter: CLK_DIV_CTRL_EDGE_CNT_EN
module clk_div_ctrl #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             clk_en,
    output logic [DIV_W-1:0] cur_div,
    output logic             busy,
    output logic             cfg_err
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
    ,
    output logic [CNT_W-1:0] edge_cnt
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    localparam logic [DIV_W-1:0] DIV_RST = DIV_W'(DEFAULT_DIV);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(2);

    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             clk_out_q, clk_out_d;
    logic             clk_en_q, clk_en_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             cfg_err_q, cfg_err_d;

    logic             cfg_ready_c;
    logic             cfg_acc;
    logic             cfg_good;
    logic             cfg_bad;
    logic [DIV_W-1:0] half;
    logic             wrap;
    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W-1:0] start_div;

    always_comb begin
        cfg_ready_c = (state_q != ST_PEND);
        cfg_acc     = cfg_valid & cfg_ready_c;
        cfg_good    = cfg_acc & (cfg_div >= DIV_MIN);
        cfg_bad     = cfg_acc & (cfg_div < DIV_MIN);
        half        = cur_div_q >> 1;
        wrap        = (cnt_q == cur_div_q - DIV_ONE);
        cnt_nxt     = wrap ? '0 : cnt_q + DIV_ONE;
        start_div   = cfg_good ? cfg_div : cur_div_q;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clk_out_d  = clk_out_q;
        clk_en_d   = 1'b0;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        cfg_err_d  = cfg_bad;

        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                clk_out_d = 1'b0;
                if (cfg_good) begin
                    cur_div_d  = cfg_div;
                    pend_div_d = cfg_div;
                end
                // Start one count short of the high phase so the first rise is two edges after en.
                if (en) begin
                    state_d = ST_RUN;
                    cnt_d   = (start_div >> 1) - DIV_ONE;
                end
            end
            ST_RUN: begin
                cnt_d     = cnt_nxt;
                clk_out_d = (cnt_nxt >= half);
                clk_en_d  = (cnt_nxt == half);
                if (wrap && !en) begin
                    state_d = ST_IDLE;
                    if (cfg_good) begin
                        cur_div_d  = cfg_div;
                        pend_div_d = cfg_div;
                    end
                end else if (cfg_good) begin
                    pend_div_d = cfg_div;
                    state_d    = ST_PEND;
                end
            end
            ST_PEND: begin
                cnt_d     = cnt_nxt;
                clk_out_d = (cnt_nxt >= half);
                clk_en_d  = (cnt_nxt == half);
                // cnt_nxt is already 0 at wrap, so the new divisor starts on a clean period.
                if (wrap) begin
                    cur_div_d = pend_div_q;
                    state_d   = en ? ST_RUN : ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                clk_out_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            clk_out_q  <= 1'b0;
            clk_en_q   <= 1'b0;
            cur_div_q  <= DIV_RST;
            pend_div_q <= DIV_RST;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clk_out_q  <= clk_out_d;
            clk_en_q   <= clk_en_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign cfg_ready = cfg_ready_c;
    assign clk_out   = clk_out_q;
    assign clk_en    = clk_en_q;
    assign cur_div   = cur_div_q;
    assign busy      = (state_q != ST_IDLE);
    assign cfg_err   = cfg_err_q;

`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        if (clk_en_d) begin
            edge_cnt_d = edge_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            edge_cnt_q <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
`endif

endmodule
